// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the sequenced control unit of the 9-bit core.
package Definitions;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Opcodes 2..5 form the ALU group; 7 is shared by NOP and HALT.
    typedef enum logic [2:0] {
        OP_STR    = 3'd0,
        OP_LDR    = 3'd1,
        OP_ALU_LO = 3'd2,
        OP_ALU_HI = 3'd5,
        OP_BRZ    = 3'd6,
        OP_SYS    = 3'd7
    } opcode_t;

    // HALT is the instruction word with every bit set to this value.
    localparam logic HALT_FILL = 1'b1;

    typedef struct packed {
        logic pc_en;
        logic branch;
        logic reg_wr_en;
        logic mem_wr_en;
        logic mem_rd_en;
        logic is_ldr;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational opcode decode; only meaningful while the sequencer is in RUN.
module ctrl_decode
    import Definitions::*;
#(
    parameter int IW  = 9,
    parameter int OPW = 3
) (
    input  logic [IW-1:0] instr,
    input  logic          zero,
    output dec_t          dec
);

    logic [OPW-1:0] op;

    assign op = instr[IW-1:IW-OPW];

    always_comb begin
        dec = '0;
        if (op == OPW'(OP_STR)) begin
            dec.mem_wr_en = 1'b1;
            dec.pc_en     = 1'b1;
        end else if (op == OPW'(OP_LDR)) begin
            dec.mem_rd_en = 1'b1;
            dec.is_ldr    = 1'b1;
        end else if (op >= OPW'(OP_ALU_LO) && op <= OPW'(OP_ALU_HI)) begin
            dec.reg_wr_en = 1'b1;
            dec.pc_en     = 1'b1;
        end else if (op == OPW'(OP_BRZ)) begin
            dec.pc_en  = 1'b1;
            dec.branch = zero;
        end else if (instr == {IW{HALT_FILL}}) begin
            dec.is_halt = 1'b1;
        end else begin
            dec.pc_en = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Sequenced control unit: FSM, load-wait counter and saturating cycle counter
// around the opcode decoder. DbgState exposes the FSM state for observation.
module ctrl_seq
    import Definitions::*;
#(
    parameter int IW      = 9,
    parameter int OPW     = 3,
    parameter int LUTW    = 2,
    parameter int MEM_LAT = 1,
    parameter int CW      = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [IW-1:0]   Instruction,
    input  logic            Zero,
    output logic            PCEn,
    output logic            PCRst,
    output logic            Branch,
    output logic [LUTW-1:0] PCTarg,
    output logic            RegWrEn,
    output logic            MemWrEn,
    output logic            MemRdEn,
    output logic            LoadInst,
    output logic [OPW-1:0]  AluOp,
    output logic            Ack,
    output logic            Busy,
    output logic [CW-1:0]   CycleCnt,
    output logic [1:0]      DbgState
);

    localparam int             WCW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(MEM_LAT - 1);

    state_t         state, state_nxt;
    logic [WCW-1:0] wcnt;
    logic           active;
    dec_t           dec;

    ctrl_decode #(.IW(IW), .OPW(OPW)) u_decode (
        .instr (Instruction),
        .zero  (Zero),
        .dec   (dec)
    );

    assign active   = (state == ST_RUN) || (state == ST_LWAIT);
    assign DbgState = state;

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset)                              wcnt <= '0;
        else if (state == ST_RUN && dec.is_ldr) wcnt <= WAIT_INIT;
        else if (state == ST_LWAIT && wcnt != '0) wcnt <= wcnt - WCW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            CycleCnt <= '0;
        else if ((state == ST_IDLE || state == ST_DONE) && Start)
            CycleCnt <= '0;
        else if (active && CycleCnt != '1)
            CycleCnt <= CycleCnt + CW'(1);
    end

    // Start is a level sampled every clock; it only has effect in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (Start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (dec.is_ldr)       state_nxt = ST_LWAIT;
                else if (dec.is_halt) state_nxt = ST_DONE;
            end
            ST_LWAIT: if (wcnt == '0) state_nxt = ST_RUN;
            ST_DONE:  if (Start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        PCEn     = 1'b0;
        PCRst    = 1'b0;
        Branch   = 1'b0;
        RegWrEn  = 1'b0;
        MemWrEn  = 1'b0;
        MemRdEn  = 1'b0;
        LoadInst = 1'b0;
        Ack      = 1'b0;
        Busy     = active;
        AluOp    = Instruction[IW-1:IW-OPW];
        PCTarg   = Instruction[LUTW-1:0];
        case (state)
            ST_IDLE: PCRst = Start & ~Reset;
            ST_RUN: begin
                PCEn    = dec.pc_en;
                Branch  = dec.branch;
                RegWrEn = dec.reg_wr_en;
                MemWrEn = dec.mem_wr_en;
                MemRdEn = dec.mem_rd_en;
            end
            ST_LWAIT: begin
                MemRdEn = 1'b1;
                // A reset landing on the write-back cycle must not commit the load.
                if (wcnt == '0 && !Reset) begin
                    LoadInst = 1'b1;
                    RegWrEn  = 1'b1;
                    PCEn     = 1'b1;
                end
            end
            ST_DONE: begin
                Ack   = 1'b1;
                PCRst = Start & ~Reset;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: main instance with MEM_LAT=3, plus a small
// CW=2 / MEM_LAT=1 instance for counter saturation and single-cycle load wait.
module tb_ctrl_seq;
    import Definitions::*;

    localparam logic [8:0] I_NOP  = 9'b111_000_000;
    localparam logic [8:0] I_ALU  = 9'b010_000_001;
    localparam logic [8:0] I_STR  = 9'b000_000_000;
    localparam logic [8:0] I_BRZ2 = 9'b110_000_010;
    localparam logic [8:0] I_BRZ3 = 9'b110_000_011;
    localparam logic [8:0] I_LDR  = 9'b001_000_011;
    localparam logic [8:0] I_LDR0 = 9'b001_000_000;
    localparam logic [8:0] I_HALT = 9'h1FF;

    // {PCEn,PCRst,Branch,RegWrEn,MemWrEn,MemRdEn,LoadInst,Ack,Busy}
    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_PCRST = 9'b010000000;
    localparam logic [8:0] C_NOP   = 9'b100000001;
    localparam logic [8:0] C_ALU   = 9'b100100001;
    localparam logic [8:0] C_STR   = 9'b100010001;
    localparam logic [8:0] C_BR    = 9'b101000001;
    localparam logic [8:0] C_LDI   = 9'b000001001;
    localparam logic [8:0] C_LDW   = 9'b100101101;
    localparam logic [8:0] C_HALT  = 9'b000000001;
    localparam logic [8:0] C_ACK   = 9'b000000010;
    localparam logic [8:0] C_ACKRS = 9'b010000010;

    logic       Clk, Reset, Start, Zero;
    logic [8:0] Instruction;
    logic       PCEn, PCRst, Branch, RegWrEn, MemWrEn, MemRdEn, LoadInst, Ack, Busy;
    logic [1:0] PCTarg, DbgState;
    logic [2:0] AluOp;
    logic [15:0] CycleCnt;

    logic       s_start, s_zero;
    logic [8:0] s_instr;
    logic       s_pcen, s_pcrst, s_branch, s_regwr, s_memwr, s_memrd, s_load, s_ack, s_busy;
    logic [1:0] s_targ, s_state, s_cnt;
    logic [2:0] s_aluop;

    logic [31:0] obs, s_obs, exp_w;
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    ctrl_seq #(.IW(9), .OPW(3), .LUTW(2), .MEM_LAT(3), .CW(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction), .Zero(Zero),
        .PCEn(PCEn), .PCRst(PCRst), .Branch(Branch), .PCTarg(PCTarg), .RegWrEn(RegWrEn),
        .MemWrEn(MemWrEn), .MemRdEn(MemRdEn), .LoadInst(LoadInst), .AluOp(AluOp),
        .Ack(Ack), .Busy(Busy), .CycleCnt(CycleCnt), .DbgState(DbgState)
    );

    ctrl_seq #(.IW(9), .OPW(3), .LUTW(2), .MEM_LAT(1), .CW(2)) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(s_start), .Instruction(s_instr), .Zero(s_zero),
        .PCEn(s_pcen), .PCRst(s_pcrst), .Branch(s_branch), .PCTarg(s_targ), .RegWrEn(s_regwr),
        .MemWrEn(s_memwr), .MemRdEn(s_memrd), .LoadInst(s_load), .AluOp(s_aluop),
        .Ack(s_ack), .Busy(s_busy), .CycleCnt(s_cnt), .DbgState(s_state)
    );

    assign obs   = {PCEn, PCRst, Branch, RegWrEn, MemWrEn, MemRdEn, LoadInst, Ack, Busy,
                    DbgState, PCTarg, AluOp, CycleCnt};
    assign s_obs = {s_pcen, s_pcrst, s_branch, s_regwr, s_memwr, s_memrd, s_load, s_ack, s_busy,
                    s_state, s_targ, s_aluop, 14'd0, s_cnt};

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ew(input logic [8:0] c, input state_t st,
                                       input logic [8:0] ins, input logic [15:0] cnt);
        return {c, st, ins[1:0], ins[8:6], cnt};
    endfunction

    // Driver tasks
    task automatic drive(input logic rst, input logic st, input logic [8:0] ins, input logic z);
        Reset = rst; Start = st; Instruction = ins; Zero = z;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, I_NOP, 1'b0);
        s_start = 1'b0; s_instr = I_NOP; s_zero = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ew(C_NONE, ST_IDLE, I_NOP, 16'd0));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_reset[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
            drive(1'b0, 1'b0, I_NOP, 1'b0);
        end
    endtask

    task automatic test_start();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, i == 0, I_NOP, 1'b0);
            exp_q.push_back(ew(i == 0 ? C_PCRST : C_NOP, i == 0 ? ST_IDLE : ST_RUN,
                               I_NOP, (i == 0) ? 16'd0 : 16'(i - 1)));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_start[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    task automatic test_alu_str();
        logic [8:0] ins [2] = '{I_ALU, I_STR};
        logic [8:0] ctl [2] = '{C_ALU, C_STR};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, i == 1, ins[i], 1'b0);  // Start in RUN must be ignored
            exp_q.push_back(ew(ctl[i], ST_RUN, ins[i], 16'(4 + i)));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_alu_str[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [8:0] ins [3] = '{I_BRZ2, I_BRZ2, I_BRZ3};
        logic       zf  [3] = '{1'b1, 1'b0, 1'b1};
        logic [8:0] ctl [3] = '{C_BR, C_NOP, C_BR};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, ins[i], zf[i]);
            exp_q.push_back(ew(ctl[i], ST_RUN, ins[i], 16'(6 + i)));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_branch[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    // Two loads issued back to back, then an ALU op; Start pulses inside LWAIT.
    task automatic test_back_to_back();
        logic [8:0] ctl [9] = '{C_LDI, C_LDI, C_LDI, C_LDW, C_LDI, C_LDI, C_LDI, C_LDW, C_ALU};
        state_t     st  [9] = '{ST_RUN, ST_LWAIT, ST_LWAIT, ST_LWAIT,
                                ST_RUN, ST_LWAIT, ST_LWAIT, ST_LWAIT, ST_RUN};
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, i == 1 || i == 6, (i == 8) ? I_ALU : I_LDR, 1'b0);
            exp_q.push_back(ew(ctl[i], st[i], (i == 8) ? I_ALU : I_LDR, 16'(9 + i)));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_back_to_back[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [8:0] ins [5] = '{I_HALT, I_NOP, I_NOP, I_NOP, I_NOP};
        logic       stv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] ctl [5] = '{C_HALT, C_ACK, C_ACK, C_ACKRS, C_NOP};
        state_t     st  [5] = '{ST_RUN, ST_DONE, ST_DONE, ST_DONE, ST_RUN};
        logic [15:0] cnt [5] = '{16'd18, 16'd19, 16'd19, 16'd19, 16'd0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, stv[i], ins[i], 1'b0);
            exp_q.push_back(ew(ctl[i], st[i], ins[i], cnt[i]));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_halt[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    task automatic test_reset_lwait();
        logic       rst [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ctl [4] = '{C_LDI, C_LDI, C_NONE, C_NONE};
        state_t     st  [4] = '{ST_RUN, ST_LWAIT, ST_IDLE, ST_IDLE};
        logic [15:0] cnt [4] = '{16'd1, 16'd2, 16'd0, 16'd0};
        for (int i = 0; i < 4; i++) begin
            drive(rst[i], 1'b0, I_LDR, 1'b0);
            exp_q.push_back(ew(ctl[i], st[i], I_LDR, cnt[i]));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL test_reset_lwait[%0d] got=%h exp=%h", i, obs, exp_w);
            end
            tick();
        end
    endtask

    // CW=2 instance: counter sticks at 3; MEM_LAT=1 load writes back on its only wait cycle.
    task automatic test_saturate();
        logic [8:0] ins [11];
        logic [8:0] ctl [11];
        state_t     st  [11];
        logic [1:0] cnt [11];
        for (int i = 0; i < 7; i++) begin
            ins[i] = I_NOP;
            ctl[i] = (i == 0) ? C_PCRST : C_NOP;
            st[i]  = (i == 0) ? ST_IDLE : ST_RUN;
            cnt[i] = (i <= 1) ? 2'd0 : ((i - 1 > 3) ? 2'd3 : 2'(i - 1));
        end
        ins[7] = I_LDR0; ctl[7] = C_LDI;  st[7] = ST_RUN;   cnt[7] = 2'd3;
        ins[8] = I_LDR0; ctl[8] = C_LDW;  st[8] = ST_LWAIT; cnt[8] = 2'd3;
        ins[9] = I_HALT; ctl[9] = C_HALT; st[9] = ST_RUN;   cnt[9] = 2'd3;
        ins[10] = I_NOP; ctl[10] = C_ACK; st[10] = ST_DONE; cnt[10] = 2'd3;
        for (int i = 0; i < 11; i++) begin
            s_start = (i == 0);
            s_instr = ins[i];
            exp_q.push_back(ew(ctl[i], st[i], ins[i], {14'd0, cnt[i]}));
            #2;
            exp_w = exp_q.pop_front();
            checks++;
            if (s_obs !== exp_w) begin
                errors++;
                $display("FAIL test_saturate[%0d] got=%h exp=%h", i, s_obs, exp_w);
            end
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Instruction = I_NOP; Zero = 1'b0;
        s_start = 1'b0; s_instr = I_NOP; s_zero = 1'b0;
        test_reset();
        test_start();
        test_alu_str();
        test_branch();
        test_back_to_back();
        test_halt();
        test_reset_lwait();
        test_saturate();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Sequenced control unit for the 9-bit core: successor to the purely combinational control decoder, parametrised in instruction, opcode and branch-LUT widths and memory read latency. Holds a small FSM that gates the program counter, stalls on multi-cycle loads, conditions branches on the ALU zero flag, halts with a sticky `Ack`, and counts executed cycles. Sits between instruction ROM/ALU flags and the fetch unit, register file and data memory.

## Interface
- `IW`, 9: instruction width
- `OPW`, 3: opcode width, taken from `Instruction[IW-1:IW-OPW]`
- `LUTW`, 2: branch-target LUT index width
- `MEM_LAT`, 1: data-memory read latency in cycles (>=1)
- `CW`, 16: cycle-counter width

- `Clk` input 1: clock; one clock domain
- `Reset` input 1: synchronous, active-high reset
- `Start` input 1: begin/restart program
- `Instruction` input IW: current machine code
- `Zero` input 1: ALU zero flag
- `PCEn` output 1: fetch unit advances PC this cycle
- `PCRst` output 1: fetch unit clears PC to 0
- `Branch` output 1: fetch unit loads target from LUT instead of PC+1
- `PCTarg` output LUTW: LUT index, `Instruction[LUTW-1:0]`
- `RegWrEn` output 1: register-file write
- `MemWrEn` output 1: data-memory write
- `MemRdEn` output 1: data-memory read strobe
- `LoadInst` output 1: reg-file write data from memory, not ALU
- `AluOp` output OPW: opcode forwarded to ALU
- `Ack` output 1: program done
- `Busy` output 1: in RUN or LWAIT
- `CycleCnt` output CW: cycles spent in RUN+LWAIT

## Operation
- States: IDLE, RUN, LWAIT, DONE. Reset -> IDLE, wait counter 0, `CycleCnt`=0.
- IDLE: all enables 0. `Start`=1 -> RUN, `PCRst`=1 that cycle, `CycleCnt` cleared.
- RUN, decode by opcode (all outputs default 0, `AluOp` always = opcode):
  - 000 STR: `MemWrEn`=1, `PCEn`=1.
  - 001 LDR: `MemRdEn`=1, `PCEn`=0, -> LWAIT with wait counter = MEM_LAT-1.
  - 010-101 ALU: `RegWrEn`=1, `PCEn`=1.
  - 110 BRZ: `PCEn`=1; `Branch`=`Zero`.
  - 111, all IW bits 1 (HALT): `PCEn`=0, -> DONE.
  - 111 otherwise NOP: `PCEn`=1.
- LWAIT: `MemRdEn` held 1. Counter nonzero -> decrement, stay. Counter 0 -> `LoadInst`=1, `RegWrEn`=1, `PCEn`=1, -> RUN.
- DONE: `Ack`=1, all enables 0. `Start`=1 -> RUN with `PCRst`=1 and `CycleCnt` cleared (restart); else hold.
- `Start` ignored in RUN/LWAIT.
- `CycleCnt` increments on each RUN/LWAIT cycle, saturates at 2^CW-1, held in IDLE/DONE.

## Timing
- Decode outputs are combinational from state and `Instruction` (same-cycle); `Ack`, `Busy` depend on state only.
- LDR occupies MEM_LAT+1 cycles: one RUN issue cycle plus MEM_LAT LWAIT cycles; write-back and PC advance on the last.
- HALT: `Ack` rises the cycle after HALT is presented.
- `Reset` wins over every event including `Start`; mid-load reset aborts with no reg write.
- `PCRst` and `PCEn` never both 1.

## Structure
- Package `Definitions`: opcode enum (STR, LDR, BRZ, NOP/HALT group), state enum, HALT pattern constant.
- Sub-module `ctrl_decode`: combinational opcode -> enable decode used in RUN; FSM, wait counter and cycle counter in `ctrl_seq`.

## Test plan
- Reset, then `Start` pulse -> `PCRst`=1 one cycle, `Busy`=1, `CycleCnt`=0 then counts 1,2,3.
- ALU op 9'b010_000_001 then STR 9'b000_000_000 -> `RegWrEn`=1 then `MemWrEn`=1, `PCEn`=1 both cycles.
- MEM_LAT=3, LDR -> `PCEn`=0 for 3 cycles, `MemRdEn`=1 for 4, `LoadInst`/`RegWrEn`=1 on 4th only.
- BRZ 9'b110_000_010 with `Zero`=1 -> `Branch`=1, `PCTarg`=2; with `Zero`=0 -> `Branch`=0.
- HALT 9'h1FF -> next cycle `Ack`=1, `CycleCnt` frozen; `Start` -> restart, `Ack`=0.
- `Reset` during LWAIT -> IDLE next cycle, all outputs 0, no `RegWrEn` pulse.
